// File: rtl/alu_accu_seq_pkg.sv
// Shared definitions for the alu_accu_seq accumulator datapath.
//   - op_sel encodings (OP_PASSA .. OP_CLR)
//   - two-state sequencer type used by the optional multiply
//     (enabled by ALU_ACCU_SEQ_MUL_EN)
package alu_accu_seq_pkg;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_PASSB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_NOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_ADC   = 3'b110;
  localparam logic [2:0] OP_CLR   = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_accu_seq_if.sv
// Operation handshake and result bundle between the control sequencer
// (master) and the accumulator datapath (slave).
//   op_valid/op_ready : request handshake, accepted when both are high
//   op_sel, acc_sel   : operation code and accumulator index
//   oprnd, oprnd_en   : operand B and its buffer enable (B=0 when low)
//   wr_en             : write the result back to the selected accumulator
//   res_valid         : one-cycle completion pulse
//   result/carry/zero : registered result and flags
interface alu_accu_seq_if #(
  parameter int WIDTH = 4,
  parameter int NACC  = 4
);
  localparam int SELW = $clog2(NACC);

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_sel;
  logic [SELW-1:0]  acc_sel;
  logic [WIDTH-1:0] oprnd;
  logic             oprnd_en;
  logic             wr_en;
  logic             res_valid;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output op_valid, op_sel, acc_sel, oprnd, oprnd_en, wr_en,
    input  op_ready, res_valid, result, carry, zero
  );

  modport slave (
    input  op_valid, op_sel, acc_sel, oprnd, oprnd_en, wr_en,
    output op_ready, res_valid, result, carry, zero
  );

endinterface

// File: rtl/alu_accu_seq_core.sv
// alu_accu_core: purely combinational WIDTH-bit ALU.
//   a, b     : operands
//   op       : operation code
//   carry_in : current carry flag (used by add-with-carry)
//   y        : WIDTH+1-bit result; bit WIDTH is carry/borrow
// Multiply and clear both yield 0 here; the multi-cycle product is
// built in the top level.
module alu_accu_core
  import alu_accu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             carry_in,
  output logic [WIDTH:0]   y
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] c_ext;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign c_ext = {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    y = '0;
    case (op)
      OP_PASSA: y = a_ext;
      // Wraps at WIDTH+1 bits, so bit WIDTH is the borrow.
      OP_SUB:   y = a_ext - b_ext;
      OP_PASSB: y = b_ext;
      OP_ADD:   y = a_ext + b_ext;
      OP_NOR:   y = {1'b0, ~(a | b)};
      OP_ADC:   y = a_ext + b_ext + c_ext;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_accu_seq.sv
// alu_accu_seq: accumulator bank + ALU with registered flags and a
// valid/ready operation handshake.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   io      : operation/result bundle (slave side)
//   bus_en  : drive bus with result, otherwise high-impedance
//   bus     : tri-state copy of result
//   acc_dbg : combinational view of accumulator[io.acc_sel]
// Optional feature macro: ALU_ACCU_SEQ_MUL_EN enables the multi-cycle
// shift-add multiply (op 101). Without it op 101 completes in one cycle
// with result 0 and op_ready is constantly high.
module alu_accu_seq
  import alu_accu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NACC  = 4
) (
  input  logic             clk,
  input  logic             reset,
  alu_accu_seq_if.slave    io,
  input  logic             bus_en,
  output wire [WIDTH-1:0]  bus,
  output logic [WIDTH-1:0] acc_dbg
);

  localparam int SELW = $clog2(NACC);

  logic [WIDTH-1:0] acc_reg [NACC];
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             zero_reg;
  logic             res_valid_reg;

  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH:0]   alu_y;
  logic             op_fire;
  logic             single_done;
  logic             op_ready_int;

  // Completion bundle: whichever path finishes this edge.
  logic             done;
  logic [WIDTH-1:0] done_data;
  logic             done_carry;
  logic             done_zero;
  logic [SELW-1:0]  wb_sel;
  logic             wb_we;
  logic [NACC-1:0]  acc_we;

  assign acc_a   = acc_reg[io.acc_sel];
  assign opnd_b  = io.oprnd_en ? io.oprnd : '0;
  assign op_fire = io.op_valid & op_ready_int;

  alu_accu_core #(.WIDTH(WIDTH)) u_core (
    .a        (acc_a),
    .b        (opnd_b),
    .op       (io.op_sel),
    .carry_in (carry_reg),
    .y        (alu_y)
  );

`ifdef ALU_ACCU_SEQ_MUL_EN
  localparam int CNTW = $clog2(WIDTH) + 1;

  state_t             state_reg;
  state_t             state_next;
  logic [CNTW-1:0]    cnt_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [SELW-1:0]    mul_sel_reg;
  logic               mul_wr_reg;
  logic [2*WIDTH-1:0] mul_sum;
  logic               mul_start;
  logic               mul_last;

  assign mul_start    = op_fire && (io.op_sel == OP_MUL);
  assign single_done  = op_fire && (io.op_sel != OP_MUL);
  assign op_ready_int = (state_reg == IDLE);
  // One multiplier bit per step: add the shifted multiplicand when set.
  assign mul_sum  = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_last = (state_reg == MUL) && (cnt_reg == CNTW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      prod_reg    <= '0;
      mul_sel_reg <= '0;
      mul_wr_reg  <= 1'b0;
    end else if (mul_start) begin
      cnt_reg     <= '0;
      mcand_reg   <= {{WIDTH{1'b0}}, acc_a};
      mplier_reg  <= opnd_b;
      prod_reg    <= '0;
      mul_sel_reg <= io.acc_sel;
      mul_wr_reg  <= io.wr_en;
    end else if (state_reg == MUL) begin
      cnt_reg    <= cnt_reg + 1'b1;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      prod_reg   <= mul_sum;
    end
  end
`else
  assign single_done  = op_fire;
  assign op_ready_int = 1'b1;
`endif

  always_comb begin
    done       = single_done;
    done_data  = alu_y[WIDTH-1:0];
    done_carry = alu_y[WIDTH];
    done_zero  = (alu_y == '0);
    wb_sel     = io.acc_sel;
    wb_we      = io.wr_en;
`ifdef ALU_ACCU_SEQ_MUL_EN
    // The handshake is closed during MUL, so this never collides with
    // a single-cycle completion.
    if (mul_last) begin
      done       = 1'b1;
      done_data  = mul_sum[WIDTH-1:0];
      done_carry = |mul_sum[2*WIDTH-1:WIDTH];
      done_zero  = (mul_sum == '0);
      wb_sel     = mul_sel_reg;
      wb_we      = mul_wr_reg;
    end
`endif
  end

  generate
    for (genvar gi = 0; gi < NACC; gi++) begin : g_acc_we
      assign acc_we[gi] = done && wb_we && (wb_sel == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      for (int i = 0; i < NACC; i++) acc_reg[i] <= '0;
    end else begin
      res_valid_reg <= done;
      if (done) begin
        result_reg <= done_data;
        carry_reg  <= done_carry;
        zero_reg   <= done_zero;
      end
      for (int i = 0; i < NACC; i++) begin
        if (acc_we[i]) acc_reg[i] <= done_data;
      end
    end
  end

  assign io.op_ready  = op_ready_int;
  assign io.res_valid = res_valid_reg;
  assign io.result    = result_reg;
  assign io.carry     = carry_reg;
  assign io.zero      = zero_reg;
  assign acc_dbg      = acc_reg[io.acc_sel];
  assign bus          = bus_en ? result_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_accu_seq.sv
// Self-checking bench for alu_accu_seq (WIDTH=4, NACC=4). Directed
// scenarios plus randomized ops checked against an arithmetic model.
module tb_alu_accu_seq;
  import alu_accu_seq_pkg::*;

`ifdef ALU_ACCU_SEQ_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       bus_en;
  wire  [3:0] bus;
  logic [3:0] acc_dbg;

  alu_accu_seq_if #(.WIDTH(4), .NACC(4)) io ();

  alu_accu_seq #(.WIDTH(4), .NACC(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .io      (io),
    .bus_en  (bus_en),
    .bus     (bus),
    .acc_dbg (acc_dbg)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int   acc_m [4];
  bit   c_m;
  bit   z_m;
  int   r_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) acc_m[i] = 0;
    c_m = 0; z_m = 0; r_m = 0;
  endfunction

  // Spec arithmetic at 5 bits: result = low 4 bits, carry = bit 4.
  function automatic void model_apply(int op, int sel, int b, bit we);
    int a;
    int full;
    a = acc_m[sel];
    full = 0;
    case (op)
      0: full = a;
      1: full = (a - b) & 31;
      2: full = b;
      3: full = a + b;
      4: full = (~(a | b)) & 15;
      6: full = a + b + int'(c_m);
      default: full = 0;
    endcase
    if (op == 5 && MUL_ON) begin
      int p;
      p = a * b;
      r_m = p % 16;
      c_m = (p >= 16);
      z_m = (p == 0);
    end else begin
      r_m = full % 16;
      c_m = (full / 16) % 2 == 1;
      z_m = (full == 0);
    end
    if (we) acc_m[sel] = r_m;
  endfunction

  task automatic run_op(input int op, input int sel, input int b, input bit en, input bit we);
    int lat;
    int exp_lat;
    @(negedge clk);
    checks++;
    if (io.op_ready !== 1'b1) begin
      failures++;
      $display("FAIL op_ready_before_accept got=%b exp=1", io.op_ready);
    end
    io.op_valid = 1'b1;
    io.op_sel   = op[2:0];
    io.acc_sel  = sel[1:0];
    io.oprnd    = b[3:0];
    io.oprnd_en = en;
    io.wr_en    = we;
    @(posedge clk); #1;
    io.op_valid = 1'b0;
    model_apply(op, sel, en ? b : 0, we);
    exp_lat = (op == 5 && MUL_ON) ? 4 : 0;
    lat = 0;
    while (io.res_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL latency op=%0d got=%0d exp=%0d", op, lat, exp_lat);
    end
    checks++;
    if (io.result !== r_m[3:0]) begin
      failures++;
      $display("FAIL result op=%0d got=%h exp=%h", op, io.result, r_m[3:0]);
    end
    checks++;
    if (io.carry !== c_m) begin
      failures++;
      $display("FAIL carry op=%0d got=%b exp=%b", op, io.carry, c_m);
    end
    checks++;
    if (io.zero !== z_m) begin
      failures++;
      $display("FAIL zero op=%0d got=%b exp=%b", op, io.zero, z_m);
    end
    #1;
    checks++;
    if (acc_dbg !== acc_m[sel][3:0]) begin
      failures++;
      $display("FAIL acc_writeback sel=%0d got=%h exp=%h", sel, acc_dbg, acc_m[sel][3:0]);
    end
    $display("op=%0d sel=%0d b=%h en=%0d we=%0d -> result=%h c=%b z=%b acc=%h",
             op, sel, b, en, we, io.result, io.carry, io.zero, acc_dbg);
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (io.result !== 4'h0 || io.carry !== 1'b0 || io.zero !== 1'b0 ||
        io.res_valid !== 1'b0 || io.op_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_outputs got=r%h c%b z%b v%b rdy%b exp=r0 c0 z0 v0 rdy1",
               tag, io.result, io.carry, io.zero, io.res_valid, io.op_ready);
    end
    for (int i = 0; i < 4; i++) begin
      io.acc_sel = i[1:0];
      #1;
      checks++;
      if (acc_dbg !== 4'h0) begin
        failures++;
        $display("FAIL %s_acc%0d got=%h exp=0", tag, i, acc_dbg);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  task automatic test_load_add();
    run_op(2, 0, 7, 1, 1);
    checks++;
    if (io.result !== 4'h7 || io.carry !== 1'b0 || io.zero !== 1'b0) begin
      failures++;
      $display("FAIL load7 got=r%h c%b z%b exp=r7 c0 z0", io.result, io.carry, io.zero);
    end
    run_op(3, 0, 10, 1, 1);
    checks++;
    if (io.result !== 4'h1 || io.carry !== 1'b1 || acc_dbg !== 4'h1) begin
      failures++;
      $display("FAIL add7_a got=r%h c%b acc%h exp=r1 c1 acc1", io.result, io.carry, acc_dbg);
    end
  endtask

  task automatic test_sub();
    run_op(2, 2, 3, 1, 1);
    run_op(1, 2, 5, 1, 0);
    checks++;
    if (io.result !== 4'hE || io.carry !== 1'b1 || io.zero !== 1'b0) begin
      failures++;
      $display("FAIL sub3m5 got=r%h c%b z%b exp=rE c1 z0", io.result, io.carry, io.zero);
    end
    run_op(2, 2, 5, 1, 1);
    run_op(1, 2, 5, 1, 0);
    checks++;
    if (io.result !== 4'h0 || io.carry !== 1'b0 || io.zero !== 1'b1) begin
      failures++;
      $display("FAIL sub5m5 got=r%h c%b z%b exp=r0 c0 z1", io.result, io.carry, io.zero);
    end
  endtask

  task automatic test_adc_oprnd_en();
    run_op(2, 3, 2, 1, 1);
    run_op(2, 2, 15, 1, 1);
    run_op(3, 2, 1, 1, 0);   // 15+1 sets carry
    run_op(6, 3, 3, 1, 0);
    checks++;
    if (io.result !== 4'h6) begin
      failures++;
      $display("FAIL adc got=%h exp=6", io.result);
    end
    run_op(3, 3, 9, 0, 0);
    checks++;
    if (io.result !== 4'h2) begin
      failures++;
      $display("FAIL oprnd_en_low got=%h exp=2", io.result);
    end
  endtask

  task automatic test_mul();
    run_op(2, 0, 3, 1, 1);
    run_op(5, 0, 5, 1, 0);
    checks++;
    if (MUL_ON ? (io.result !== 4'hF || io.carry !== 1'b0)
               : (io.result !== 4'h0 || io.zero !== 1'b1)) begin
      failures++;
      $display("FAIL mul3x5 got=r%h c%b z%b", io.result, io.carry, io.zero);
    end
    if (MUL_ON) begin
      // 6*7 with a clear request held on op_valid while busy.
      run_op(2, 1, 6, 1, 1);
      @(negedge clk);
      io.op_valid = 1'b1; io.op_sel = 3'd5; io.acc_sel = 2'd1;
      io.oprnd = 4'd7; io.oprnd_en = 1'b1; io.wr_en = 1'b1;
      @(posedge clk); #1;
      model_apply(5, 1, 7, 1);
      io.op_sel = 3'd7;
      for (int k = 1; k <= 4; k++) begin
        checks++;
        if (io.op_ready !== 1'b0 || io.res_valid !== 1'b0) begin
          failures++;
          $display("FAIL mul_busy k=%0d got=rdy%b v%b exp=rdy0 v0", k, io.op_ready, io.res_valid);
        end
        @(posedge clk); #1;
      end
      io.op_valid = 1'b0;
      checks++;
      if (io.res_valid !== 1'b1 || io.op_ready !== 1'b1 || io.result !== 4'hA || io.carry !== 1'b1) begin
        failures++;
        $display("FAIL mul6x7 got=v%b rdy%b r%h c%b exp=v1 rdy1 rA c1",
                 io.res_valid, io.op_ready, io.result, io.carry);
      end
      @(posedge clk); #1;
      checks++;
      if (acc_dbg !== 4'hA || io.res_valid !== 1'b0) begin
        failures++;
        $display("FAIL mul_ignore_busy got=acc%h v%b exp=accA v0", acc_dbg, io.res_valid);
      end
      $display("mul 6x7 with ignored clear -> result=%h acc1=%h", io.result, acc_dbg);
    end
  endtask

  task automatic test_back_to_back();
    int b1;
    int b2;
    b1 = int'($urandom_range(0, 15));
    b2 = int'($urandom_range(0, 15));
    @(negedge clk);
    io.op_valid = 1'b1; io.op_sel = OP_PASSB; io.acc_sel = 2'd1;
    io.oprnd = b1[3:0]; io.oprnd_en = 1'b1; io.wr_en = 1'b1;
    @(posedge clk); #1;
    model_apply(2, 1, b1, 1);
    io.op_sel = OP_ADD; io.oprnd = b2[3:0];
    @(posedge clk); #1;
    model_apply(3, 1, b2, 1);
    checks++;
    if (io.res_valid !== 1'b1 || io.result !== r_m[3:0] || io.carry !== c_m) begin
      failures++;
      $display("FAIL b2b_add got=v%b r%h c%b exp=v1 r%h c%b", io.res_valid, io.result, io.carry, r_m[3:0], c_m);
    end
    io.op_sel = OP_PASSA; io.wr_en = 1'b0;
    @(posedge clk); #1;
    model_apply(0, 1, b2, 0);
    io.op_valid = 1'b0;
    checks++;
    if (io.res_valid !== 1'b1 || io.result !== r_m[3:0]) begin
      failures++;
      $display("FAIL b2b_passa got=v%b r%h exp=v1 r%h", io.res_valid, io.result, r_m[3:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (io.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL res_valid_pulse got=%b exp=0", io.res_valid);
    end
    $display("back-to-back b1=%h b2=%h -> result=%h", b1, b2, io.result);
  endtask

  task automatic test_bus();
    run_op(2, 0, 9, 1, 0);
    bus_en = 1'b0;
    #1;
    checks++;
    if (bus !== 4'bzzzz && bus !== 4'b0000) begin
      failures++;
      $display("FAIL bus_hiz got=%b exp=zzzz", bus);
    end
    bus_en = 1'b1;
    #1;
    checks++;
    if (bus !== 4'h9) begin
      failures++;
      $display("FAIL bus_drive got=%h exp=9", bus);
    end
    bus_en = 1'b0;
    $display("bus check result=%h", io.result);
  endtask

  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic test_reset_mid_mul();
    run_op(2, 0, 9, 1, 1);
    run_op(2, 3, 4, 1, 1);
    @(negedge clk);
    io.op_valid = 1'b1; io.op_sel = OP_MUL; io.acc_sel = 2'd0;
    io.oprnd = 4'd3; io.oprnd_en = 1'b1; io.wr_en = 1'b1;
    @(posedge clk); #1;
    io.op_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_state("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    io.acc_sel = 2'd0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (acc_dbg !== 4'h0 || io.res_valid !== 1'b0 || io.op_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_no_writeback got=acc%h v%b rdy%b exp=acc0 v0 rdy1",
               acc_dbg, io.res_valid, io.op_ready);
    end
    $display("reset mid-operation -> acc0=%h", acc_dbg);
  endtask

  initial begin
    reset = 1'b0;
    bus_en = 1'b0;
    io.op_valid = 1'b0;
    io.op_sel = 3'd0;
    io.acc_sel = 2'd0;
    io.oprnd = 4'd0;
    io.oprnd_en = 1'b1;
    io.wr_en = 1'b0;
    model_reset();
    test_reset();
    test_load_add();
    test_sub();
    test_adc_oprnd_en();
    test_mul();
    test_back_to_back();
    test_bus();
    test_random();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_accu_seq.md
# alu_accu_seq

Parametrised successor to the 4-bit operational datapath: a bank of NACC accumulators, a WIDTH-bit ALU with registered carry/zero flags, and a valid/ready operation handshake. It adds add-with-carry, clear, and an optional multi-cycle shift-add multiply. It sits between the control sequencer, which issues operations, and the shared data bus, which it drives through a tri-state output.

## Interface
Parameters:
- WIDTH, 4, datapath width in bits; must be ≥ 2.
- NACC, 4, number of accumulators; power of 2, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an operation; high in IDLE.
- op_sel  in  3  operation code.
- acc_sel  in  $clog2(NACC)  accumulator to read and write back.
- oprnd  in  WIDTH  operand B.
- oprnd_en  in  1  operand buffer enable; when low, B is 0.
- wr_en  in  1  write the result back to the selected accumulator.
- bus_en  in  1  drive `bus`.
- res_valid  out  1  one-cycle pulse when a result completes.
- result  out  WIDTH  registered result; held between completions.
- carry  out  1  registered carry/borrow/overflow flag.
- zero  out  1  registered zero flag.
- bus  out  WIDTH  equals `result` when bus_en=1, otherwise high-impedance.
- acc_dbg  out  WIDTH  combinational view of the accumulator selected by the live acc_sel.

## Operation
- An operation is accepted at a rising edge where op_valid=1 and op_ready=1.
- op_sel, acc_sel, B and wr_en are captured at accept.
- A is the selected accumulator. B is oprnd when oprnd_en=1, otherwise 0.
- All arithmetic is done at WIDTH+1 bits.
  - result = low WIDTH bits.
  - carry = bit WIDTH.
  - zero = 1 iff all WIDTH+1 bits are 0.
- Op codes:
  - 000: pass A.
  - 001: A − B; carry is the borrow.
  - 010: pass B.
  - 011: A + B.
  - 100: bitwise NOR; carry forced to 0.
  - 101: multiply (MUL; see Configuration).
  - 110: A + B + carry (the current flag).
  - 111: clear; result 0, zero=1.
- FSM has two states, IDLE and MUL.
  - IDLE → MUL on accepting a MUL.
  - MUL → IDLE after WIDTH steps.
  - Every other op stays in IDLE.
- MUL: unsigned shift-add, one multiplier bit per cycle.
  - result = product[WIDTH-1:0].
  - carry = OR of product[2·WIDTH-1:WIDTH] (overflow).
  - zero = 1 iff the full product is 0.
- When wr_en was captured as 1, accumulator[captured acc_sel] ← result at completion. Flags update on every completion regardless of wr_en.
- op_valid while op_ready=0 is ignored; no queuing.
- Reset low, at any time including mid-MUL:
  - accumulators, result, carry, zero, res_valid → 0.
  - FSM → IDLE; op_ready=1.
  - An aborted MUL performs no writeback.

## Timing
- Single-cycle ops: accept at edge N; result, flags, writeback and res_valid=1 all at edge N.
- Back-to-back single-cycle ops complete one per cycle. An op reads A as updated by the previous edge.
- MUL:
  - Operands are captured at accept edge N and op_ready drops after N.
  - Steps run at edges N+1..N+WIDTH; completion is at edge N+WIDTH.
  - op_ready returns high after N+WIDTH, so the next accept is possible at N+WIDTH+1.
- res_valid is high for exactly one cycle per completion.
- bus and acc_dbg are combinational.

## Configuration
- ALU_ACCU_SEQ_MUL_EN defined:
  - op 101 is the multi-cycle MUL.
  - MUL FSM and multiplier registers are present.
- Undefined:
  - op 101 completes in one cycle with result=0, carry=0, zero=1.
  - op_ready is constant 1.
  - No MUL state or registers are synthesised.

## Structure
- Shared package alu_accu_seq_pkg holds:
  - op_sel encoding localparams OP_PASSA…OP_CLR;
  - FSM state typedef (IDLE, MUL).
- Sub-module alu_accu_core: purely combinational WIDTH-parametrised ALU (A, B, op, carry_in → WIDTH+1 result). The top level holds the accumulator bank, flags, handshake and the MUL FSM.

## Test plan
All scenarios use WIDTH=4, NACC=4.
- Reset: drive reset low mid-MUL → result=0, carry=0, zero=0, res_valid=0, op_ready=1, every acc_dbg=0, no writeback.
- Load/add: op 010 with oprnd=7, wr_en=1, acc 0 → result=7, C=0, Z=0, acc0=7. Then op 011 with oprnd=0xA → result=1, C=1, acc0=1.
- Sub: acc=3, op 001 with oprnd=5 → result=0xE, C=1, Z=0. acc=5, op 001 with oprnd=5 → result=0, C=0, Z=1.
- ADC and operand enable: carry=1, acc=2, op 110 with oprnd=3 → result=6. op 011 with oprnd_en=0 → result=acc.
- MUL:
  - acc=3, oprnd=5 → op_ready low 4 cycles, res_valid at 4th edge, result=0xF, C=0.
  - acc=6, oprnd=7 → result=0xA, C=1.
  - op_valid while busy is ignored.
- Bus: bus_en=0 → bus is all Z. bus_en=1 → bus equals result.
